// File: rtl/data_pipe_interconnect_m2s_rr.sv
`default_nettype none
// ============================================================================
// Module   : data_pipe_interconnect_m2s_rr
// Purpose  : N-slave to 1-master data pipe with round-robin arbitration,
//            optional packet locking on last and an output FIFO. Every beat
//            leaving the FIFO carries the index of the slave it came from.
// Ports    : clock, rst (sync, active-high), clk_en (global enable)
//            s_valid/s_data/s_last/s_ready/mask : per-slave stream inputs
//            m_valid/m_data/m_last/m_src/m_ready : master stream output
//            curr_path : currently granted slave, busy : XFER or FIFO data
// Options  : define DATA_PIPE_M2S_PRIO_EN to add the prio[NUM] input; when a
//            requesting slave has its prio bit set, arbitration is limited
//            to the prioritised requesters (same shared round-robin pointer).
// Revision : 1.0 - initial release
// ============================================================================
module data_pipe_interconnect_m2s_rr #(
    parameter int DSIZE     = 8,
    parameter int NUM       = 8,
    parameter int NSIZE     = (NUM > 1) ? $clog2(NUM) : 1,
    parameter int DEPTH     = 4,
    parameter int LOCK_LAST = 1
) (
    input  logic                 clock,
    input  logic                 rst,
    input  logic                 clk_en,
    input  logic [NUM-1:0]       s_valid,
    input  logic [NUM*DSIZE-1:0] s_data,
    input  logic [NUM-1:0]       s_last,
    output logic [NUM-1:0]       s_ready,
    input  logic [NUM-1:0]       mask,
`ifdef DATA_PIPE_M2S_PRIO_EN
    input  logic [NUM-1:0]       prio,
`endif
    output logic                 m_valid,
    output logic [DSIZE-1:0]     m_data,
    output logic                 m_last,
    output logic [NSIZE-1:0]     m_src,
    input  logic                 m_ready,
    output logic [NSIZE-1:0]     curr_path,
    output logic                 busy
);

    localparam int c_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CW = c_AW + 1;
    localparam int c_EW = NSIZE + 1 + DSIZE;
    localparam logic [c_CW-1:0] c_FULL_CNT = c_CW'(DEPTH);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_ARB  = 2'd1;
    localparam logic [1:0] c_ST_XFER = 2'd2;

    logic [1:0]       r_state;
    logic [NSIZE-1:0] r_last_grant;
    logic [NSIZE-1:0] r_curr_path;
    logic [c_EW-1:0]  r_mem [DEPTH];
    logic [c_AW-1:0]  r_wptr;
    logic [c_AW-1:0]  r_rptr;
    logic [c_CW-1:0]  r_count;

    logic [NUM-1:0]   w_req;
    logic [NUM-1:0]   w_req_eff;
    logic [NSIZE-1:0] w_grant;
    logic             w_grant_vld;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic             w_exit;
    logic [NUM-1:0]   w_s_ready;
    logic [c_EW-1:0]  w_head;

    assign w_req = s_valid & mask;

`ifdef DATA_PIPE_M2S_PRIO_EN
    logic [NUM-1:0] w_prio_req;
    assign w_prio_req = w_req & prio;
    assign w_req_eff  = (|w_prio_req) ? w_prio_req : w_req;
`else
    assign w_req_eff  = w_req;
`endif

    // Rotating search starting one past the previous winner, wrapping at NUM.
    always_comb begin
        int idx;
        idx         = 0;
        w_grant_vld = 1'b0;
        w_grant     = '0;
        for (int k = 1; k <= NUM; k++) begin
            idx = int'(r_last_grant) + k;
            if (idx >= NUM) begin
                idx = idx - NUM;
            end
            if (!w_grant_vld && w_req_eff[idx]) begin
                w_grant_vld = 1'b1;
                w_grant     = NSIZE'(idx);
            end
        end
    end

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_FULL_CNT);

    // Ready comes only from registered state and the FIFO count, so a pop in
    // the same cycle never re-opens a full FIFO (no m_ready -> s_ready path).
    always_comb begin
        w_s_ready = '0;
        if ((r_state == c_ST_XFER) && !w_full && clk_en) begin
            w_s_ready[r_curr_path] = mask[r_curr_path];
        end
    end

    assign w_push = w_s_ready[r_curr_path] & s_valid[r_curr_path];
    assign w_pop  = m_valid & m_ready;
    assign w_exit = w_push & (s_last[r_curr_path] | (LOCK_LAST == 0));

    always_ff @(posedge clock) begin
        if (rst) begin
            r_state      <= c_ST_IDLE;
            r_last_grant <= NSIZE'(NUM - 1);
            r_curr_path  <= '0;
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_count      <= '0;
        end else if (clk_en) begin
            case (r_state)
                c_ST_IDLE: r_state <= c_ST_ARB;
                c_ST_ARB: begin
                    if (w_grant_vld) begin
                        r_curr_path  <= w_grant;
                        r_last_grant <= w_grant;
                        r_state      <= c_ST_XFER;
                    end
                end
                c_ST_XFER: begin
                    if (w_exit) begin
                        r_state <= c_ST_ARB;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase

            if (w_push) begin
                r_wptr <= r_wptr + c_AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_CW'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - c_CW'(1);
            end
        end
    end

    // Storage carries no reset; validity is tracked by the count alone.
    always_ff @(posedge clock) begin
        if (!rst && clk_en && w_push) begin
            r_mem[r_wptr] <= {r_curr_path, s_last[r_curr_path],
                              s_data[int'(r_curr_path) * DSIZE +: DSIZE]};
        end
    end

    assign w_head    = r_mem[r_rptr];
    assign s_ready   = w_s_ready;
    assign m_valid   = !w_empty & clk_en;
    assign m_data    = w_empty ? '0 : w_head[DSIZE-1:0];
    assign m_last    = !w_empty & w_head[DSIZE];
    assign m_src     = w_empty ? '0 : w_head[c_EW-1 -: NSIZE];
    assign curr_path = r_curr_path;
    assign busy      = (r_state == c_ST_XFER) | !w_empty;

endmodule
`default_nettype wire

// File: tb/tb_data_pipe_interconnect_m2s_rr.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_pipe_interconnect_m2s_rr
// Purpose  : Directed self-checking bench for data_pipe_interconnect_m2s_rr.
//            Each slave is fed by a small beat generator (data = {slave,
//            beat index}); output beats are captured into a queue and
//            compared against hand-derived sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_pipe_interconnect_m2s_rr;

    localparam int NUM   = 8;
    localparam int DSIZE = 8;

    logic             clock;
    logic             rst;
    logic             clk_en;
    logic [NUM-1:0]   s_valid;
    logic [NUM*8-1:0] s_data;
    logic [NUM-1:0]   s_last;
    logic [NUM-1:0]   s_ready;
    logic [NUM-1:0]   mask;
    logic             m_valid;
    logic [7:0]       m_data;
    logic             m_last;
    logic [2:0]       m_src;
    logic             m_ready;
    logic [2:0]       curr_path;
    logic             busy;
`ifdef DATA_PIPE_M2S_PRIO_EN
    logic [NUM-1:0]   prio;
`endif

    data_pipe_interconnect_m2s_rr #(
        .DSIZE(DSIZE), .NUM(NUM), .DEPTH(4), .LOCK_LAST(1)
    ) u_dut (
        .clock(clock), .rst(rst), .clk_en(clk_en),
        .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
        .s_ready(s_ready), .mask(mask),
`ifdef DATA_PIPE_M2S_PRIO_EN
        .prio(prio),
`endif
        .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_src(m_src),
        .m_ready(m_ready), .curr_path(curr_path), .busy(busy)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int rem [NUM];
    int cnt [NUM];
    int len [NUM];
    logic [NUM-1:0] en;
    logic [31:0] obs_q [$];
    int          obs_cyc [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] bt(input int s, input bit l, input int d);
        return {20'd0, 3'(s), l, 8'(d)};
    endfunction

    function automatic logic [31:0] obs_get(input int k);
        logic [31:0] v;
        v = 32'hxxxxxxxx;
        if (k < obs_q.size()) v = obs_q[k];
        return v;
    endfunction

    task automatic drive_inputs();
        for (int i = 0; i < NUM; i++) begin
            s_valid[i]          = (rem[i] > 0) && en[i];
            s_data[i*8 +: 8]    = {4'(i), 4'(cnt[i])};
            s_last[i]           = (((cnt[i] + 1) % len[i]) == 0);
        end
    endtask

    task automatic feed(input int i, input int n, input int l);
        rem[i] = n;
        len[i] = l;
        cnt[i] = 0;
    endtask

    // One clock: sample handshakes on the falling edge, update stimulus
    // just after the rising edge.
    task automatic cycle();
        logic [NUM-1:0] fire;
        @(negedge clock);
        if (m_valid && m_ready) begin
            obs_q.push_back({20'd0, m_src, m_last, m_data});
            obs_cyc.push_back(cyc);
        end
        fire = s_valid & s_ready;
        @(posedge clock);
        #1;
        cyc++;
        for (int i = 0; i < NUM; i++) begin
            if (fire[i]) begin
                cnt[i]++;
                rem[i]--;
            end
        end
        drive_inputs();
    endtask

    task automatic run(input int n);
        for (int t = 0; t < n; t++) cycle();
    endtask

    task automatic wait_cnt(input int i, input int n, input string tag);
        for (int t = 0; t < 40 && cnt[i] < n; t++) cycle();
        chk(tag, cnt[i], n);
    endtask

    task automatic clear_obs();
        obs_q.delete();
        obs_cyc.delete();
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_s_ready"}, 32'(s_ready), 0);
        chk({tag, "_m_valid"}, 32'(m_valid), 0);
        chk({tag, "_m_data"},  32'(m_data), 0);
        chk({tag, "_m_last"},  32'(m_last), 0);
        chk({tag, "_m_src"},   32'(m_src), 0);
        chk({tag, "_busy"},    32'(busy), 0);
        chk({tag, "_path"},    32'(curr_path), 0);
    endtask

    initial begin
        rst = 1'b1; clk_en = 1'b1; mask = '1; m_ready = 1'b1; en = '1;
        s_valid = '0; s_data = '0; s_last = '0;
`ifdef DATA_PIPE_M2S_PRIO_EN
        prio = '0;
`endif
        for (int i = 0; i < NUM; i++) feed(i, 0, 1);
        drive_inputs();
        run(2);
        chk_idle_outputs("reset");
        rst = 1'b0;

        // Two 2-beat packets from slaves 0 and 3.
        clear_obs();
        feed(0, 2, 2);
        feed(3, 2, 2);
        drive_inputs();
        run(16);
        chk("t1_count", obs_q.size(), 4);
        chk("t1_b0", obs_get(0), bt(0, 0, 8'h00));
        chk("t1_b1", obs_get(1), bt(0, 1, 8'h01));
        chk("t1_b2", obs_get(2), bt(3, 0, 8'h30));
        chk("t1_b3", obs_get(3), bt(3, 1, 8'h31));
        if (obs_cyc.size() == 4) begin
            chk("t1_back_to_back", obs_cyc[1] - obs_cyc[0], 1);
            chk("t1_bubble", obs_cyc[2] - obs_cyc[1], 2);
        end else begin
            chk("t1_timing_beats", obs_cyc.size(), 4);
        end

        // All slaves request 1-beat packets; grant order wraps 0..7,0..7.
        rst = 1'b1;
        run(1);
        rst = 1'b0;
        clear_obs();
        for (int i = 0; i < NUM; i++) feed(i, 2, 1);
        drive_inputs();
        run(45);
        chk("t2_count", obs_q.size(), 16);
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("t2_b%0d", k), obs_get(k), bt(k % 8, 1, {4'(k % 8), 4'(k / 8)}));
        end

        // Backpressure: 6-beat packet with m_ready low fills the FIFO.
        clear_obs();
        m_ready = 1'b0;
        feed(2, 6, 6);
        drive_inputs();
        run(10);
        chk("t3_accepted", cnt[2], 4);
        chk("t3_s_ready", 32'(s_ready), 0);
        chk("t3_m_valid", 32'(m_valid), 1);
        chk("t3_head", {20'd0, m_src, m_last, m_data}, bt(2, 0, 8'h20));
        chk("t3_busy", 32'(busy), 1);
        m_ready = 1'b1;
        run(15);
        chk("t3_count", obs_q.size(), 6);
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("t3_b%0d", k), obs_get(k), bt(2, k == 5, 8'h20 + k));
        end

        // Mask dropped mid-packet on slave 1 while slave 5 waits.
        clear_obs();
        feed(1, 4, 4);
        drive_inputs();
        wait_cnt(1, 1, "t4_first_beat");
        feed(5, 2, 2);
        mask[1] = 1'b0;
        drive_inputs();
        for (int t = 0; t < 3; t++) begin
            cycle();
            chk("t4_masked_ready", 32'(s_ready), 0);
        end
        mask = '1;
        drive_inputs();
        run(20);
        chk("t4_count", obs_q.size(), 6);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("t4_s1_b%0d", k), obs_get(k), bt(1, k == 3, 8'h10 + k));
        end
        chk("t4_s5_b0", obs_get(4), bt(5, 0, 8'h50));
        chk("t4_s5_b1", obs_get(5), bt(5, 1, 8'h51));

        // clk_en low for 5 cycles mid-packet.
        clear_obs();
        feed(4, 6, 6);
        drive_inputs();
        wait_cnt(4, 2, "t5_two_beats");
        clk_en = 1'b0;
        for (int t = 0; t < 5; t++) begin
            cycle();
            chk("t5_quiet", {23'd0, s_ready, m_valid}, 0);
        end
        chk("t5_frozen_cnt", cnt[4], 2);
        clk_en = 1'b1;
        run(15);
        chk("t5_count", obs_q.size(), 6);
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("t5_b%0d", k), obs_get(k), bt(4, k == 5, 8'h40 + k));
        end

        // Reset pulse mid-packet on slave 6; next grant must be slave 0.
        feed(6, 4, 4);
        drive_inputs();
        wait_cnt(6, 2, "t6_two_beats");
        en[6] = 1'b0;
        rst   = 1'b1;
        drive_inputs();
        cycle();
        chk_idle_outputs("t6_rst");
        rst   = 1'b0;
        en[6] = 1'b1;
        clear_obs();
        feed(0, 1, 1);
        drive_inputs();
        run(20);
        chk("t6_count", obs_q.size(), 3);
        chk("t6_b0", obs_get(0), bt(0, 1, 8'h00));
        chk("t6_b1", obs_get(1), bt(6, 0, 8'h62));
        chk("t6_b2", obs_get(2), bt(6, 1, 8'h63));

`ifdef DATA_PIPE_M2S_PRIO_EN
        // Prioritised slave 6 wins over slave 1 despite the pointer.
        clear_obs();
        prio = 8'h40;
        feed(1, 1, 1);
        feed(6, 1, 1);
        drive_inputs();
        wait_cnt(6, 1, "t7_prio_beat");
        prio = '0;
        run(15);
        chk("t7_count", obs_q.size(), 2);
        chk("t7_b0", obs_get(0), bt(6, 1, 8'h60));
        chk("t7_b1", obs_get(1), bt(1, 1, 8'h10));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/data_pipe_interconnect_m2s_rr.md
Name: data_pipe_interconnect_M2S_rr

Overview:
- N-slave to 1-master data pipe interconnect with round-robin arbitration, packet locking on last, and a parametrised output FIFO.
- Next generation of the M2S data pipe; replaces the external sw/vld_sw path select with internal arbitration.
- Tags every output beat with its source index.
- Used ahead of shared AXI-stream/axu sinks.

Parameters:
- DSIZE, 8, data width.
- NUM, 8, number of slave ports (2..32).
- NSIZE, derived ($clog2(NUM), min 1), index width.
- DEPTH, 4, output FIFO entries, power of 2, >=2.
- LOCK_LAST, 1, 1 = grant held until beat with last, 0 = re-arbitrate after every beat.

Ports:
- clock  in  1  single clock.
- rst  in  1  synchronous reset, active-high.
- clk_en  in  1  global enable; when low no handshake and no state change.
- s_valid  in  NUM  per-slave valid.
- s_data  in  NUM*DSIZE  per-slave data, slave i at [i*DSIZE +: DSIZE].
- s_last  in  NUM  per-slave end-of-packet.
- s_ready  out  NUM  per-slave ready.
- mask  in  NUM  per-slave request enable.
- m_valid  out  1  master valid.
- m_data  out  DSIZE  master data.
- m_last  out  1  master end-of-packet.
- m_src  out  NSIZE  source slave index of current m_data.
- m_ready  in  1  master ready.
- curr_path  out  NSIZE  currently granted slave.
- busy  out  1  high in XFER state or FIFO non-empty.

Behaviour:
- Reset: state=IDLE, FIFO flushed, last_grant=NUM-1, curr_path=0.
- Reset: s_ready=0, m_valid=0, m_data=0, m_last=0, m_src=0, busy=0.
- Reset mid-packet discards the FIFO contents and the lock.
- State IDLE: one cycle after reset, then ARB.
- State ARB: req = s_valid & mask. If req=0, stay in ARB.
- ARB grant: first set bit of req scanning last_grant+1 upward, wrapping at NUM-1 to 0. Register it into curr_path and last_grant; go to XFER.
- ARB costs one bubble cycle per packet. No s_ready is asserted in ARB.
- State XFER: s_ready[i] = (i==curr_path) & mask[i] & !fifo_full & clk_en. All other s_ready bits are 0.
- s_ready depends only on registered state and FIFO count. No combinational m_ready -> s_ready path. When full, ready stays low even if a pop occurs the same cycle.
- Beat accept: s_valid[curr_path] & s_ready[curr_path] pushes {curr_path, s_last, data} into the FIFO.
- XFER exit: an accepted beat with s_last=1, or any accepted beat when LOCK_LAST=0, returns to ARB next cycle. Otherwise stay in XFER.
- mask[curr_path] falling mid-packet deasserts s_ready but keeps the lock; the packet is never split or interleaved.
- s_valid dropping mid-packet keeps the lock; wait.
- FIFO: m_valid = !empty & clk_en; {m_src, m_last, m_data} = head entry.
- Pop on m_valid & m_ready. Simultaneous push and pop when not full keeps the count.
- Latency: a beat accepted in cycle t is visible on m_* in cycle t+1 if the FIFO was empty.
- Throughput: DEPTH>=2 sustains 1 beat/cycle within a packet with m_ready held high.
- Payload stays stable while m_valid & !m_ready.
- Counters: count width $clog2(DEPTH)+1; read and write pointers wrap modulo DEPTH.
- clk_en=0: FSM, pointers and last_grant all frozen; all s_ready=0, m_valid=0.

Optional Feature:
- Macro DATA_PIPE_M2S_PRIO_EN.
- Defined: adds input prio [NUM]. In ARB, if any (req & prio) bit is set, grant is round-robin among those bits only; otherwise round-robin over req. One shared last_grant pointer.
- Undefined: no prio port; pure round-robin as above.

Test Plan:
- Reset then slaves 0 and 3 valid, 2-beat packets, m_ready=1 -> m_src sequence 0,0,3,3; m_last on beats 2 and 4; one bubble cycle between packets.
- All NUM=8 slaves request continuously, 1-beat packets with last=1 -> grant order 0..7,0 (wrap). Holds with LOCK_LAST=0 and no last.
- Slave 2 packet of 6 beats, m_ready=0 -> s_ready drops after DEPTH=4 beats. Raise m_ready -> remaining 2 beats pass, order and data intact, no loss.
- Slave 1 mid-packet with mask[1] cleared for 3 cycles while slave 5 is valid -> no slave-5 beat appears before slave 1's last.
- clk_en low for 5 cycles mid-transfer -> no handshakes and m_valid=0. Stream resumes with the same next beat. rst pulse mid-packet -> all outputs 0 and next grant goes to slave 0.
- With DATA_PIPE_M2S_PRIO_EN, slaves 1 and 6 valid with prio=8'h40 -> slave 6 granted first, then slave 1 after prio is cleared.
